// File: rtl/usb_pkg.sv
// Shared USB definitions: PID codes, CRC5 constants, token geometry and the
// token decoder state encoding. Imported by the token encoder and decoder.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  // Token geometry, expressed as running bit counts after each field.
  localparam logic [4:0] TOKEN_BITS = 5'd24;
  localparam logic [4:0] PID_BITS   = 5'd8;
  localparam logic [4:0] BODY_END   = 5'd19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_BODY,
    ST_CRC,
    ST_WAIT_END
  } dec_state_t;

  // One serial step of the x^5+x^2+1 LFSR, data fed LSB-first.
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[4];
    return {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  // True when the PID nibble is one of the four token types.
  function automatic logic is_token_pid(input logic [3:0] p);
    case (p)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // Full PID byte check: complement check nibble plus token type.
  function automatic logic pid_byte_ok(input logic [7:0] b);
    return (b[7:4] == ~b[3:0]) && is_token_pid(b[3:0]);
  endfunction

endpackage

// File: rtl/usb_token_decoder_if.sv
// Bit-stream input and decoded-token result bundle of the USB token decoder.
// master = upstream bit-unstuffer / protocol side, slave = the decoder.
interface usb_token_decoder_if;
  logic        bitIn;
  logic        bitValid;
  logic        pktStart;
  logic        pktEnd;
  logic        tokValid;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [10:0] frameNum;
  logic        pidErr;
  logic        crcErr;
  logic        lenErr;

  modport master (
    output bitIn, bitValid, pktStart, pktEnd,
    input  tokValid, pid, addr, endp, frameNum, pidErr, crcErr, lenErr
  );

  modport slave (
    input  bitIn, bitValid, pktStart, pktEnd,
    output tokValid, pid, addr, endp, frameNum, pidErr, crcErr, lenErr
  );
endinterface

// File: rtl/crc5_serial.sv
// Serial USB CRC5 (x^5+x^2+1). init has priority over en; crc_next exposes
// the value the register will take so callers can judge the residual in the
// same cycle the last bit arrives.
module crc5_serial
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       en,
  input  logic       din,
  output logic [4:0] crc,
  output logic [4:0] crc_next
);

  // Next LFSR value: reload, shift one bit, or hold.
  always_comb begin
    crc_next = crc;
    if (init) begin
      crc_next = CRC5_INIT;
    end else if (en) begin
      crc_next = crc5_step(crc, din);
    end
  end

  // LFSR register, seeded with the init pattern on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC5_INIT;
    end else begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/usb_token_decoder.sv
// USB token decoder: takes an unstuffed LSB-first token bit stream, checks
// PID, length and CRC5, and presents the decoded fields with a one-cycle
// tokValid strobe on the edge after pktEnd.
module usb_token_decoder
  import usb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  usb_token_decoder_if.slave  bus
);

  dec_state_t  state_q, state_n;
  logic [4:0]  cnt_q, cnt_n;
  logic [23:0] cap_q, cap_n;
  logic        crc_init, crc_en;
  logic [4:0]  crc_q, crc_n;
  logic        end_evt;

  logic        tok_valid_q;
  logic [3:0]  pid_q;
  logic [6:0]  addr_q;
  logic [3:0]  endp_q;
  logic        pid_err_q, crc_err_q, len_err_q;

  crc5_serial u_crc (
    .clk      (clk),
    .rst      (rst),
    .init     (crc_init),
    .en       (crc_en),
    .din      (bus.bitIn),
    .crc      (crc_q),
    .crc_next (crc_n)
  );

  // Consume this cycle's bit (if any), then decide whether pktEnd closes a packet.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_n  = state_q;
    cnt_n    = cnt_q;
    cap_n    = cap_q;
    crc_init = 1'b0;
    crc_en   = 1'b0;

    if (bus.bitValid) begin
      if (bus.pktStart) begin
        // A start always restarts, aborting any packet in flight.
        state_n  = ST_PID;
        cnt_n    = 5'd1;
        cap_n    = {23'b0, bus.bitIn};
        crc_init = 1'b1;
      end else if (state_q != ST_IDLE) begin
        cnt_n = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        // Bits past the 24th are counted only; cnt_q >= 24 matches no slot.
        for (int i = 0; i < int'(TOKEN_BITS); i++) begin
          if (cnt_q == 5'(i)) cap_n[i] = bus.bitIn;
        end
        crc_en = (state_q == ST_BODY) || (state_q == ST_CRC);
        case (state_q)
          ST_PID:  if (cnt_n == PID_BITS)   state_n = ST_BODY;
          ST_BODY: if (cnt_n == BODY_END)   state_n = ST_CRC;
          ST_CRC:  if (cnt_n == TOKEN_BITS) state_n = ST_WAIT_END;
          default: ;
        endcase
      end
    end

    end_evt = bus.pktEnd && (state_n != ST_IDLE);
  end

  // Sequencer state plus registered result fields, loaded only on end of packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 5'd0;
      // NOTE: the capture register is cleared on reset too; unreceived fields must read 0.
      cap_q       <= 24'd0;
      tok_valid_q <= 1'b0;
      pid_q       <= 4'd0;
      addr_q      <= 7'd0;
      endp_q      <= 4'd0;
      pid_err_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q     <= end_evt ? ST_IDLE : state_n;
      cnt_q       <= cnt_n;
      cap_q       <= cap_n;
      tok_valid_q <= end_evt;
      if (end_evt) begin
        pid_q     <= cap_n[3:0];
        addr_q    <= cap_n[14:8];
        endp_q    <= cap_n[18:15];
        pid_err_q <= !pid_byte_ok(cap_n[7:0]);
        crc_err_q <= (crc_n != CRC5_RESIDUAL);
        len_err_q <= (cnt_n != TOKEN_BITS);
      end
    end
  end

  assign bus.tokValid = tok_valid_q;
  assign bus.pid      = pid_q;
  assign bus.addr     = addr_q;
  assign bus.endp     = endp_q;
  assign bus.frameNum = {endp_q, addr_q};
  assign bus.pidErr   = pid_err_q;
  assign bus.crcErr   = crc_err_q;
  assign bus.lenErr   = len_err_q;

endmodule

// File: tb/tb_usb_token_decoder.sv
// Directed bench for usb_token_decoder. Expected tokens are queued when a
// packet is driven and compared by a monitor when tokValid is seen.
module tb_usb_token_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_token_decoder_if bus();

  usb_token_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    logic       pe;
    logic       ce;
    logic       le;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n_strobes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Pop and compare one expected token per observed strobe.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.tokValid === 1'b1) begin
      n_strobes++;
      check("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pid",      bus.pid,      e.pid);
        check("addr",     bus.addr,     e.addr);
        check("endp",     bus.endp,     e.endp);
        check("frameNum", bus.frameNum, {e.endp, e.addr});
        check("pidErr",   bus.pidErr,   e.pe);
        check("crcErr",   bus.crcErr,   e.ce);
        check("lenErr",   bus.lenErr,   e.le);
      end
    end
  end

  // Token bits in wire order; CRC5 goes out c4 first.
  function automatic logic [31:0] tok(input logic [7:0] pid8, input logic [6:0] a,
                                      input logic [3:0] ep, input logic [4:0] c);
    return {8'h00, c[0], c[1], c[2], c[3], c[4], ep, a, pid8};
  endfunction

  task automatic push(input logic [3:0] p, input logic [6:0] a, input logic [3:0] ep,
                      input logic pe, input logic ce, input logic le);
    exp_t e;
    e = '{pid: p, addr: a, endp: ep, pe: pe, ce: ce, le: le};
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic b, input logic s, input logic e);
    bus.bitValid = v;
    bus.bitIn    = b;
    bus.pktStart = s;
    bus.pktEnd   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.bitValid = 1'b0;
    bus.bitIn    = 1'b0;
    bus.pktStart = 1'b0;
    bus.pktEnd   = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input bit gaps, input bit end_on_last);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      drive(1'b1, v[i], i == 0, end_on_last && (i == n - 1));
    end
  endtask

  task automatic end_pkt();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Called #1 after the edge that sampled pktEnd: the strobe must already be up.
  task automatic expect_strobe(input string tag);
    idle_inputs();
    check(tag, bus.tokValid, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tokValid"}, bus.tokValid, 0);
    check({tag, "_pid"},      bus.pid,      0);
    check({tag, "_addr"},     bus.addr,     0);
    check({tag, "_endp"},     bus.endp,     0);
    check({tag, "_frameNum"}, bus.frameNum, 0);
    check({tag, "_pidErr"},   bus.pidErr,   0);
    check({tag, "_crcErr"},   bus.crcErr,   0);
    check({tag, "_lenErr"},   bus.lenErr,   0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v_in, v_out, v;
    int s0;

    v_in  = tok(8'h69, 7'h15, 4'hE, 5'b10111);   // IN
    v_out = tok(8'hE1, 7'h3A, 4'hA, 5'b11100);   // OUT

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs_zero("reset");

    // IN token, gap-free, separate pktEnd cycle.
    push(4'h9, 7'h15, 4'hE, 0, 0, 0);
    send_bits(v_in, 24, 0, 0);
    end_pkt();
    expect_strobe("in_latency");
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("hold_tokValid", bus.tokValid, 0);
    check("hold_pid", bus.pid, 4'h9);
    check("hold_addr", bus.addr, 7'h15);

    // OUT token with random bitValid gaps.
    push(4'h1, 7'h3A, 4'hA, 0, 0, 0);
    send_bits(v_out, 24, 1, 0);
    end_pkt();
    expect_strobe("out_latency");
    drain();

    // pktEnd with the last bit, then pktStart on the very next cycle.
    push(4'h9, 7'h15, 4'hE, 0, 0, 0);
    send_bits(v_in, 24, 0, 1);
    expect_strobe("same_cycle_end");
    push(4'h1, 7'h3A, 4'hA, 0, 0, 0);
    send_bits(v_out, 24, 0, 0);
    end_pkt();
    expect_strobe("back_to_back");
    drain();

    // Bit 12 (addr[4]) flipped: CRC must catch it.
    push(4'h9, 7'h05, 4'hE, 0, 1, 0);
    send_bits(v_in ^ 32'h0000_1000, 24, 0, 0);
    end_pkt();
    expect_strobe("crc_flip");
    drain();

    // A5 is a well-formed SOF; B5 breaks the check nibble; 4B is DATA1.
    push(4'h5, 7'h15, 4'hE, 0, 0, 0);
    send_bits({v_in[31:8], 8'hA5}, 24, 0, 0);
    end_pkt();
    expect_strobe("sof_ok");
    push(4'h5, 7'h15, 4'hE, 1, 0, 0);
    send_bits({v_in[31:8], 8'hB5}, 24, 0, 0);
    end_pkt();
    expect_strobe("pid_nibble");
    push(4'hB, 7'h15, 4'hE, 1, 0, 0);
    send_bits({v_in[31:8], 8'h4B}, 24, 0, 0);
    end_pkt();
    expect_strobe("pid_data");
    drain();

    // Short packet: 20 bits; CRC register holds 5'b10101 at that point.
    push(4'h9, 7'h15, 4'hE, 0, 1, 1);
    send_bits(v_in, 20, 0, 0);
    end_pkt();
    expect_strobe("len_short");
    // Long packet: 25 bits; extra bit is counted but not fed to CRC.
    v = v_in | 32'h0100_0000;
    push(4'h9, 7'h15, 4'hE, 0, 0, 1);
    send_bits(v, 25, 0, 0);
    end_pkt();
    expect_strobe("len_long");
    drain();

    // Restart at bit 10: only the second packet produces a strobe.
    s0 = n_strobes;
    send_bits(v_out, 10, 0, 0);
    push(4'h9, 7'h15, 4'hE, 0, 0, 0);
    send_bits(v_in, 24, 0, 0);
    end_pkt();
    expect_strobe("abort_restart");
    drain();
    check("abort_one_strobe", n_strobes - s0, 1);

    // Reset at bit 15, then a stray pktEnd while idle.
    s0 = n_strobes;
    send_bits(v_in, 15, 0, 0);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs_zero("mid_rst");
    end_pkt();
    idle_inputs();
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_strobe", n_strobes - s0, 0);
    check("idle_end_ignored", bus.tokValid, 0);

    // Recovery after reset.
    push(4'h1, 7'h3A, 4'hA, 0, 0, 0);
    send_bits(v_out, 24, 1, 0);
    end_pkt();
    expect_strobe("recover");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
